// File: rtl/hazard_pkg.sv
// hazard_pkg -- shared types for the hazard/forwarding controller.
//   fsel_e      : EX operand-select encoding that drives forward_mux_a/b
//   hz_state_e  : controller state (RUN, LU_STALL, FREEZE)
//   stage_rec_t : destination-register record tracked for EX, MEM and WB
//   BUBBLE_REC  : record value for an empty pipeline slot
package hazard_pkg;

  // Register-address width carried inside stage records; the controller's
  // REG_ADDR_W parameter must match it.
  localparam int REC_RD_W = 5;

  typedef enum logic [1:0] {
    FSEL_RF  = 2'b00,
    FSEL_MEM = 2'b01,
    FSEL_WB  = 2'b10
  } fsel_e;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FREEZE   = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic                valid;
    logic [REC_RD_W-1:0] rd;
    logic                reg_wr;
    logic                is_load;
  } stage_rec_t;

  localparam stage_rec_t BUBBLE_REC = '0;

endpackage

// File: rtl/hazard_fwd_ctrl_fwd_sel_calc.sv
// fwd_sel_calc -- combinational select for one EX operand.
// Decides, from one ID source register and the current EX/MEM records, where
// that operand should come from when the instruction reaches EX next cycle.
// Ports:
//   rs      : ID source register for this operand
//   uses_rs : the instruction actually reads rs
//   ex_rec  : record of the instruction now in EX (will be in MEM next cycle)
//   mem_rec : record of the instruction now in MEM (will be in WB next cycle)
//   sel     : FSEL_MEM / FSEL_WB / FSEL_RF
module fwd_sel_calc
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = REC_RD_W
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic                  uses_rs,
  input  stage_rec_t            ex_rec,
  input  stage_rec_t            mem_rec,
  output fsel_e                 sel
);

  logic rs_nz;
  logic ex_hit;
  logic mem_hit;
  logic unused_mem_load;

  assign rs_nz = (rs != '0);

  // A load in EX has no ALU result to forward; the load-use stall covers it.
  assign ex_hit  = uses_rs & ex_rec.valid & ex_rec.reg_wr & (ex_rec.rd == rs)
                 & rs_nz & ~ex_rec.is_load;
  assign mem_hit = mem_rec.valid & mem_rec.reg_wr & (mem_rec.rd == rs) & rs_nz;

  // The WB-side value is the final result, so load or ALU makes no difference.
  assign unused_mem_load = mem_rec.is_load;

  // The nearer producer wins.
  always_comb begin
    sel = FSEL_RF;
    if (ex_hit) begin
      sel = FSEL_MEM;
    end else if (mem_hit) begin
      sel = FSEL_WB;
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl -- hazard and forwarding controller for the 5-stage pipe.
// Registers the EX operand selects (FselA/FselB) so they line up with the
// instruction entering EX, and raises the load-use stall and the branch flush.
// Optional build macro: HAZARD_STATS_EN adds saturating statistics counters.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   valid_id .. is_load_id: decoded fields of the instruction in ID
//   branch_taken_ex       : branch/jump in EX resolved taken
//   mem_busy              : data memory not ready, freeze the whole pipe
//   FselA, FselB          : EX operand selects (00 regfile, 01 MEM, 10 WB)
//   stall_pc, stall_if_id : hold PC / IF-ID register
//   flush_if_id           : clear IF-ID register
//   flush_id_ex           : insert bubble into ID-EX
//   stall_cnt, fwd_cnt, flush_cnt (HAZARD_STATS_EN only): event counters
module hazard_fwd_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = REC_RD_W,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_id,
  input  logic [REG_ADDR_W-1:0] rs1_id,
  input  logic [REG_ADDR_W-1:0] rs2_id,
  input  logic                  uses_rs1_id,
  input  logic                  uses_rs2_id,
  input  logic [REG_ADDR_W-1:0] rd_id,
  input  logic                  reg_wr_id,
  input  logic                  is_load_id,
  input  logic                  branch_taken_ex,
  input  logic                  mem_busy,
  output logic [1:0]            FselA,
  output logic [1:0]            FselB,
  output logic                  stall_pc,
  output logic                  stall_if_id,
  output logic                  flush_if_id,
  output logic                  flush_id_ex
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      fwd_cnt,
  output logic [CNT_W-1:0]      flush_cnt
`endif
);

  hz_state_e  state_q, state_d;
  stage_rec_t ex_q, ex_d;
  stage_rec_t mem_q, mem_d;
  stage_rec_t wb_q, wb_d;
  fsel_e      fsel_a_q, fsel_a_d;
  fsel_e      fsel_b_q, fsel_b_d;

  stage_rec_t id_rec;
  fsel_e      calc_a;
  fsel_e      calc_b;
  logic       load_use;
  logic       bubble_ex;
  logic       unused_wb;

  assign id_rec = '{valid: valid_id, rd: rd_id, reg_wr: reg_wr_id, is_load: is_load_id};

  // WB is tracked so the record chain mirrors the pipe; nothing here reads it.
  assign unused_wb = ^wb_q;

  fwd_sel_calc #(.REG_ADDR_W(REG_ADDR_W)) u_sel_a (
    .rs      (rs1_id),
    .uses_rs (uses_rs1_id),
    .ex_rec  (ex_q),
    .mem_rec (mem_q),
    .sel     (calc_a)
  );

  fwd_sel_calc #(.REG_ADDR_W(REG_ADDR_W)) u_sel_b (
    .rs      (rs2_id),
    .uses_rs (uses_rs2_id),
    .ex_rec  (ex_q),
    .mem_rec (mem_q),
    .sel     (calc_b)
  );

  // In LU_STALL the EX slot is always the bubble inserted by the stall, so a
  // second back-to-back load-use stall cannot occur.
  assign load_use = valid_id & (state_q != LU_STALL)
                  & ex_q.valid & ex_q.is_load & ex_q.reg_wr & (ex_q.rd != '0)
                  & ((uses_rs1_id & (rs1_id == ex_q.rd)) |
                     (uses_rs2_id & (rs2_id == ex_q.rd)));

  // mem_busy freezes everything in any state. Otherwise every state behaves as
  // RUN: branch flush beats the load-use stall, and either one turns the next
  // EX record into a bubble, which also forces the registered selects to 00.
  always_comb begin
    state_d     = state_q;
    ex_d        = ex_q;
    mem_d       = mem_q;
    wb_d        = wb_q;
    fsel_a_d    = fsel_a_q;
    fsel_b_d    = fsel_b_q;
    stall_pc    = 1'b0;
    stall_if_id = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    bubble_ex   = 1'b0;

    if (mem_busy) begin
      state_d     = FREEZE;
      stall_pc    = 1'b1;
      stall_if_id = 1'b1;
    end else begin
      state_d = RUN;
      if (branch_taken_ex) begin
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
        bubble_ex   = 1'b1;
      end else if (load_use) begin
        state_d     = LU_STALL;
        stall_pc    = 1'b1;
        stall_if_id = 1'b1;
        flush_id_ex = 1'b1;
        bubble_ex   = 1'b1;
      end

      ex_d  = bubble_ex ? BUBBLE_REC : id_rec;
      mem_d = ex_q;
      wb_d  = mem_q;

      if (bubble_ex || !valid_id) begin
        fsel_a_d = FSEL_RF;
        fsel_b_d = FSEL_RF;
      end else begin
        fsel_a_d = calc_a;
        fsel_b_d = calc_b;
      end
    end

    // Control outputs read as idle while reset is held.
    if (rst) begin
      stall_pc    = 1'b0;
      stall_if_id = 1'b0;
      flush_if_id = 1'b0;
      flush_id_ex = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      ex_q     <= BUBBLE_REC;
      mem_q    <= BUBBLE_REC;
      wb_q     <= BUBBLE_REC;
      fsel_a_q <= FSEL_RF;
      fsel_b_q <= FSEL_RF;
    end else begin
      state_q  <= state_d;
      ex_q     <= ex_d;
      mem_q    <= mem_d;
      wb_q     <= wb_d;
      fsel_a_q <= fsel_a_d;
      fsel_b_q <= fsel_b_d;
    end
  end

  assign FselA = fsel_a_q;
  assign FselB = fsel_b_q;

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [1:0]       fwd_inc;
  logic [CNT_W:0]   fwd_sum;

  // Forward events are counted when a nonzero select is loaded, not while it
  // is merely held by a freeze; up to two per cycle, so saturate via carry.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    fwd_inc     = 2'b00;
    if ((state_q == LU_STALL) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush_if_id && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
    if (!mem_busy) begin
      fwd_inc = {1'b0, (fsel_a_d != FSEL_RF)} + {1'b0, (fsel_b_d != FSEL_RF)};
    end
    fwd_sum   = {1'b0, fwd_cnt_q} + {{(CNT_W-1){1'b0}}, fwd_inc};
    fwd_cnt_d = fwd_sum[CNT_W] ? '1 : fwd_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb_hazard_fwd_ctrl -- self-checking bench for hazard_fwd_ctrl.
// Directed instruction sequences from a vector table, then random traffic
// checked against a queue-based model of which instruction sits in which stage.
module tb_hazard_fwd_ctrl;

  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_id;
  logic [4:0] rs1_id;
  logic [4:0] rs2_id;
  logic       uses_rs1_id;
  logic       uses_rs2_id;
  logic [4:0] rd_id;
  logic       reg_wr_id;
  logic       is_load_id;
  logic       branch_taken_ex;
  logic       mem_busy;
  logic [1:0] FselA;
  logic [1:0] FselB;
  logic       stall_pc;
  logic       stall_if_id;
  logic       flush_if_id;
  logic       flush_id_ex;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt;
  logic [31:0] fwd_cnt;
  logic [31:0] flush_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_fwd_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .valid_id        (valid_id),
    .rs1_id          (rs1_id),
    .rs2_id          (rs2_id),
    .uses_rs1_id     (uses_rs1_id),
    .uses_rs2_id     (uses_rs2_id),
    .rd_id           (rd_id),
    .reg_wr_id       (reg_wr_id),
    .is_load_id      (is_load_id),
    .branch_taken_ex (branch_taken_ex),
    .mem_busy        (mem_busy),
    .FselA           (FselA),
    .FselB           (FselB),
    .stall_pc        (stall_pc),
    .stall_if_id     (stall_if_id),
    .flush_if_id     (flush_if_id),
    .flush_id_ex     (flush_id_ex)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cnt       (stall_cnt),
    .fwd_cnt         (fwd_cnt),
    .flush_cnt       (flush_cnt)
`endif
  );

  // One cycle of ID-side inputs plus the outputs expected during that cycle.
  // fa/fb are the registered selects visible in this cycle (decided last cycle).
  typedef struct {
    logic       rst;
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
    logic       br;
    logic       busy;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       spc;
    logic       sif;
    logic       fif;
    logic       fie;
  } vec_t;

  typedef struct {
    logic       valid;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
  } instr_t;

  vec_t   vecs[$];
  instr_t pipe[$];   // pipe[0] is in EX, pipe[1] in MEM, pipe[2] in WB
  logic [1:0] m_fa;
  logic [1:0] m_fb;
  logic       m_known;

  task automatic applyStimulus(input vec_t s);
    rst             = s.rst;
    valid_id        = s.v;
    rs1_id          = s.rs1;
    rs2_id          = s.rs2;
    uses_rs1_id     = s.u1;
    uses_rs2_id     = s.u2;
    rd_id           = s.rd;
    reg_wr_id       = s.wr;
    is_load_id      = s.ld;
    branch_taken_ex = s.br;
    mem_busy        = s.busy;
  endtask

  task automatic checkOutput(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input vec_t s, input logic chk_sel);
    checkOutput({tag, " stall_pc"},    {1'b0, stall_pc},    {1'b0, s.spc});
    checkOutput({tag, " stall_if_id"}, {1'b0, stall_if_id}, {1'b0, s.sif});
    checkOutput({tag, " flush_if_id"}, {1'b0, flush_if_id}, {1'b0, s.fif});
    checkOutput({tag, " flush_id_ex"}, {1'b0, flush_id_ex}, {1'b0, s.fie});
    if (chk_sel) begin
      checkOutput({tag, " FselA"}, FselA, s.fa);
      checkOutput({tag, " FselB"}, FselB, s.fb);
    end
  endtask

  // Where operand rs comes from when this instruction reaches EX: search the
  // two instructions ahead of it, nearest first.
  function automatic logic [1:0] modelSource(input logic [4:0] rs, input logic uses);
    for (int age = 0; age < 2; age++) begin
      if (pipe[age].valid && pipe[age].wr && rs != 5'd0 && pipe[age].rd == rs) begin
        if (age == 1) return 2'b10;
        if (uses && !pipe[age].ld) return 2'b01;
      end
    end
    return 2'b00;
  endfunction

  function automatic logic modelLoadUse(input vec_t s);
    instr_t p;
    p = pipe[0];
    return s.v && p.valid && p.ld && p.wr && p.rd != 5'd0 &&
           ((s.u1 && s.rs1 == p.rd) || (s.u2 && s.rs2 == p.rd));
  endfunction

  task automatic modelReset();
    instr_t b;
    b = '{valid: 1'b0, rd: 5'd0, wr: 1'b0, ld: 1'b0};
    pipe.delete();
    repeat (3) pipe.push_back(b);
    m_fa    = 2'b00;
    m_fb    = 2'b00;
    m_known = 1'b1;
  endtask

  task automatic modelAdvance(input vec_t s);
    instr_t issued;
    logic   drop;
    if (s.rst) begin
      modelReset();
    end else if (!s.busy) begin
      drop = s.br || modelLoadUse(s);
      if (drop || !s.v) begin
        m_fa = 2'b00;
        m_fb = 2'b00;
      end else begin
        m_fa = modelSource(s.rs1, s.u1);
        m_fb = modelSource(s.rs2, s.u2);
      end
      if (drop) issued = '{valid: 1'b0, rd: 5'd0, wr: 1'b0, ld: 1'b0};
      else      issued = '{valid: s.v, rd: s.rd, wr: s.wr, ld: s.ld};
      pipe.push_front(issued);
      void'(pipe.pop_back());
    end
  endtask

  initial begin
    vec_t s;
    logic lu;

    // rst v rs1 rs2 u1 u2 rd wr ld br busy | fa fb | spc sif fif fie
    // ADD x5 ; ADD x6,x5,x7 back-to-back
    vecs.push_back('{N,Y,5'd1,5'd2,Y,Y,5'd5,Y,N,N,N, 2'd0,2'd0, N,N,N,N});
    vecs.push_back('{N,Y,5'd5,5'd7,Y,Y,5'd6,Y,N,N,N, 2'd0,2'd0, N,N,N,N});
    vecs.push_back('{N,N,5'd0,5'd0,N,N,5'd0,N,N,N,N, 2'd1,2'd0, N,N,N,N});
    // ADD x5 ; invalid slot naming x5 ; SUB x8,x1,x5
    vecs.push_back('{N,Y,5'd1,5'd2,Y,Y,5'd5,Y,N,N,N, 2'd0,2'd0, N,N,N,N});
    vecs.push_back('{N,N,5'd5,5'd5,Y,Y,5'd0,N,N,N,N, 2'd0,2'd0, N,N,N,N});
    vecs.push_back('{N,Y,5'd1,5'd5,Y,Y,5'd8,Y,N,N,N, 2'd0,2'd0, N,N,N,N});
    vecs.push_back('{N,N,5'd0,5'd0,N,N,5'd0,N,N,N,N, 2'd0,2'd2, N,N,N,N});
    // x5 written in both EX and MEM: nearer one wins
    vecs.push_back('{N,Y,5'd1,5'd2,Y,Y,5'd5,Y,N,N,N, 2'd0,2'd0, N,N,N,N});
    vecs.push_back('{N,Y,5'd1,5'd2,Y,Y,5'd5,Y,N,N,N, 2'd0,2'd0, N,N,N,N});
    vecs.push_back('{N,Y,5'd5,5'd5,Y,Y,5'd9,Y,N,N,N, 2'd0,2'd0, N,N,N,N});
    vecs.push_back('{N,N,5'd0,5'd0,N,N,5'd0,N,N,N,N, 2'd1,2'd1, N,N,N,N});
    // LW x5 ; ADD x6,x5,x5 -> one stall, then both from WB
    vecs.push_back('{N,Y,5'd1,5'd0,Y,N,5'd5,Y,Y,N,N, 2'd0,2'd0, N,N,N,N});
    vecs.push_back('{N,Y,5'd5,5'd5,Y,Y,5'd6,Y,N,N,N, 2'd0,2'd0, Y,Y,N,Y});
    vecs.push_back('{N,Y,5'd5,5'd5,Y,Y,5'd6,Y,N,N,N, 2'd0,2'd0, N,N,N,N});
    vecs.push_back('{N,N,5'd0,5'd0,N,N,5'd0,N,N,N,N, 2'd2,2'd2, N,N,N,N});
    // LW x0 ; reader of x0
    vecs.push_back('{N,Y,5'd1,5'd0,Y,N,5'd0,Y,Y,N,N, 2'd0,2'd0, N,N,N,N});
    vecs.push_back('{N,Y,5'd0,5'd0,Y,Y,5'd6,Y,N,N,N, 2'd0,2'd0, N,N,N,N});
    vecs.push_back('{N,N,5'd0,5'd0,N,N,5'd0,N,N,N,N, 2'd0,2'd0, N,N,N,N});
    // load-use coinciding with a taken branch
    vecs.push_back('{N,Y,5'd1,5'd0,Y,N,5'd5,Y,Y,N,N, 2'd0,2'd0, N,N,N,N});
    vecs.push_back('{N,Y,5'd5,5'd5,Y,Y,5'd6,Y,N,Y,N, 2'd0,2'd0, N,N,Y,Y});
    vecs.push_back('{N,N,5'd0,5'd0,N,N,5'd0,N,N,N,N, 2'd0,2'd0, N,N,N,N});
    // branch suppresses what would have been 01/01
    vecs.push_back('{N,Y,5'd1,5'd2,Y,Y,5'd7,Y,N,N,N, 2'd0,2'd0, N,N,N,N});
    vecs.push_back('{N,Y,5'd7,5'd7,Y,Y,5'd8,Y,N,Y,N, 2'd0,2'd0, N,N,Y,Y});
    vecs.push_back('{N,N,5'd0,5'd0,N,N,5'd0,N,N,N,N, 2'd0,2'd0, N,N,N,N});
    // forwarding pair frozen for three cycles
    vecs.push_back('{N,Y,5'd1,5'd2,Y,Y,5'd5,Y,N,N,N, 2'd0,2'd0, N,N,N,N});
    vecs.push_back('{N,Y,5'd5,5'd7,Y,Y,5'd6,Y,N,N,N, 2'd0,2'd0, N,N,N,N});
    vecs.push_back('{N,Y,5'd6,5'd5,Y,Y,5'd9,Y,N,N,Y, 2'd1,2'd0, Y,Y,N,N});
    vecs.push_back('{N,Y,5'd6,5'd5,Y,Y,5'd9,Y,N,N,Y, 2'd1,2'd0, Y,Y,N,N});
    vecs.push_back('{N,Y,5'd6,5'd5,Y,Y,5'd9,Y,N,N,Y, 2'd1,2'd0, Y,Y,N,N});
    vecs.push_back('{N,Y,5'd6,5'd5,Y,Y,5'd9,Y,N,N,N, 2'd1,2'd0, N,N,N,N});
    vecs.push_back('{N,Y,5'd9,5'd1,Y,Y,5'd10,Y,N,N,N, 2'd1,2'd2, N,N,N,N});
    // reset while frozen
    vecs.push_back('{N,N,5'd0,5'd0,N,N,5'd0,N,N,N,Y, 2'd1,2'd0, Y,Y,N,N});
    vecs.push_back('{Y,N,5'd0,5'd0,N,N,5'd0,N,N,N,Y, 2'd1,2'd0, N,N,N,N});
    vecs.push_back('{N,N,5'd0,5'd0,N,N,5'd0,N,N,N,N, 2'd0,2'd0, N,N,N,N});
    vecs.push_back('{N,Y,5'd10,5'd9,Y,Y,5'd12,Y,N,N,N, 2'd0,2'd0, N,N,N,N});
    vecs.push_back('{N,N,5'd0,5'd0,N,N,5'd0,N,N,N,N, 2'd0,2'd0, N,N,N,N});
    // branch arriving during a freeze is retaken after release
    vecs.push_back('{N,Y,5'd1,5'd2,Y,Y,5'd5,Y,N,N,N, 2'd0,2'd0, N,N,N,N});
    vecs.push_back('{N,Y,5'd5,5'd5,Y,Y,5'd6,Y,N,Y,Y, 2'd0,2'd0, Y,Y,N,N});
    vecs.push_back('{N,Y,5'd5,5'd5,Y,Y,5'd6,Y,N,Y,N, 2'd0,2'd0, N,N,Y,Y});
    vecs.push_back('{N,N,5'd0,5'd0,N,N,5'd0,N,N,N,N, 2'd0,2'd0, N,N,N,N});

    // Reset state, checked while reset is still held.
    s = '{Y,N,5'd0,5'd0,N,N,5'd0,N,N,N,N, 2'd0,2'd0, N,N,N,N};
    applyStimulus(s);
    repeat (2) @(posedge clk);
    #1;
    #2;
    checkAll("reset", s, 1'b1);
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      #2;
      checkAll($sformatf("row%0d", i), vecs[i], 1'b1);
      @(posedge clk);
      #1;
    end

    // Random traffic against the stage-queue model; small register range to
    // provoke frequent dependencies.
    m_known = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      s.rst  = (c < 2) || ($urandom_range(0, 63) == 0);
      s.v    = ($urandom_range(0, 9) < 8);
      s.rs1  = 5'($urandom_range(0, 7));
      s.rs2  = 5'($urandom_range(0, 7));
      s.u1   = ($urandom_range(0, 9) < 8);
      s.u2   = ($urandom_range(0, 9) < 6);
      s.rd   = 5'($urandom_range(0, 7));
      s.wr   = ($urandom_range(0, 9) < 8);
      s.ld   = ($urandom_range(0, 9) < 3);
      s.br   = ($urandom_range(0, 9) == 0);
      s.busy = ($urandom_range(0, 9) == 0);
      s.fa   = m_fa;
      s.fb   = m_fb;
      lu     = m_known && modelLoadUse(s);
      s.spc  = !s.rst && (s.busy || (!s.br && lu));
      s.sif  = s.spc;
      s.fif  = !s.rst && !s.busy && s.br;
      s.fie  = !s.rst && !s.busy && (s.br || lu);
      applyStimulus(s);
      #2;
      checkAll($sformatf("rand%0d", c), s, m_known);
      if (m_known || s.rst) modelAdvance(s);
      @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
